// File: rtl/core_pkg.sv
// core_pkg: opcodes, hazard FSM states and register-address width shared across the RV32 core.
package core_pkg;
    localparam int REG_AW = 5;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_SB = 7'b1100011;
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2, FREEZE = 2'd3} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (inc && !(&count)) count <= count + 1'b1;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-flush / memory-wait controller for the 5-stage pipeline.
// Control outputs are combinational so bubbles reach the pipeline in the same cycle.
module hazard_ctrl #(
    parameter int REG_AW            = core_pkg::REG_AW,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              ctrl_src,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              pipe_en,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    import core_pkg::*;
    localparam logic [2:0] LS_N = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FL_N = 3'(FLUSH_CYCLES - 1);
    state_t state_q, nxt, ret_q, nxt_ret;
    logic [2:0] cnt_q, nxt_cnt;
    logic uses_rs1, uses_rs2, load_use, stall_inc, flush_inc;
    assign uses_rs2 = (id_opcode == OP_R) || (id_opcode == OP_S) || (id_opcode == OP_SB);
    assign uses_rs1 = uses_rs2 || (id_opcode == OP_I) || (id_opcode == OP_LW);
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((uses_rs1 && id_rs1 == ex_rd) || (uses_rs2 && id_rs2 == ex_rd));
    assign state = state_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= nxt;
            ret_q   <= nxt_ret;
            cnt_q   <= nxt_cnt;
        end
    end
    // Freeze wins over everything; a freeze cycle in STALL/FLUSH issues no bubble and leaves cnt alone.
    always_comb begin
        nxt        = state_q;
        nxt_ret    = ret_q;
        nxt_cnt    = cnt_q;
        ctrl_src   = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        pipe_en    = 1'b1;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (state_q == FREEZE || mem_busy) begin
            pipe_en    = 1'b0;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            if (state_q != FREEZE) begin
                nxt_ret = state_q;
                nxt     = FREEZE;
            end else if (!mem_busy) begin
                nxt = ret_q;
            end
        end else if (state_q == STALL) begin
            ctrl_src   = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            stall_inc  = 1'b1;
            nxt_cnt    = cnt_q - 3'd1;
            if (cnt_q == 3'd1) nxt = RUN;
        end else if (state_q == FLUSH) begin
            ctrl_src   = 1'b1;
            ifid_flush = 1'b1;
            flush_inc  = 1'b1;
            nxt_cnt    = cnt_q - 3'd1;
            if (cnt_q == 3'd1) nxt = RUN;
        end else if (ex_branch_taken) begin
            ctrl_src   = 1'b1;
            ifid_flush = 1'b1;
            flush_inc  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                nxt_cnt = FL_N;
                nxt     = FLUSH;
            end
        end else if (load_use) begin
            ctrl_src   = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            stall_inc  = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                nxt_cnt = LS_N;
                nxt     = STALL;
            end
        end
    end
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .inc(stall_inc), .count(stall_count)
    );
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst_n(rst_n), .inc(flush_inc), .count(flush_count)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table with expected per-cycle outputs, checked through a scoreboard queue.
module tb_hazard_ctrl;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, S = 7'b0100011, LUI = 7'b0110111;
    localparam logic [4:0] IDLE = 5'b01101, STL = 5'b10001, FLO = 5'b11111, FRZ = 5'b00000;
    typedef struct {
        bit rst; bit sel;
        logic [6:0] op; logic [4:0] rs1, rs2, rd; logic mr, br, mb;
        logic [4:0] ctl; logic [1:0] st; int sc, fc;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b1;
    logic [6:0] id_opcode = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_busy = 1'b0;
    logic cs_a, pw_a, iw_a, if_a, pe_a, cs_b, pw_b, iw_b, if_b, pe_b;
    logic [1:0] st_a, st_b;
    logic [3:0] sc_a, fc_a;
    logic [15:0] sc_b, fc_b;
    logic [4:0] ctl_a, ctl_b;
    vec_t vecs[$];
    vec_t exp_q[$];
    vec_t v, e;
    int checks = 0, errors = 0;
    assign ctl_a = {cs_a, pw_a, iw_a, if_a, pe_a};
    assign ctl_b = {cs_b, pw_b, iw_b, if_b, pe_b};
    always #5 clk = ~clk;
    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .ctrl_src(cs_a), .pc_write(pw_a), .ifid_write(iw_a),
        .ifid_flush(if_a), .pipe_en(pe_a), .state(st_a), .stall_count(sc_a), .flush_count(fc_a)
    );
    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(3), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .ctrl_src(cs_b), .pc_write(pw_b), .ifid_write(iw_b),
        .ifid_flush(if_b), .pipe_en(pe_b), .state(st_b), .stall_count(sc_b), .flush_count(fc_b)
    );
    task automatic chk(input string what, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d expected %0d", what, idx, got, exp);
        end
    endtask
    task automatic add(input bit rst, input bit sel, input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic mr, input logic [4:0] rd, input logic br,
                       input logic mb, input logic [4:0] ctl, input logic [1:0] st,
                       input int sc, input int fc);
        vec_t t;
        t.rst = rst; t.sel = sel; t.op = op; t.rs1 = rs1; t.rs2 = rs2; t.mr = mr; t.rd = rd;
        t.br = br; t.mb = mb; t.ctl = ctl; t.st = st; t.sc = sc; t.fc = fc;
        vecs.push_back(t);
    endtask
    task automatic chk_reset(input int idx);
        chk("rst_ctl_a", idx, int'(ctl_a), int'(IDLE));
        chk("rst_state_a", idx, int'(st_a), 0);
        chk("rst_cnt_a", idx, int'(sc_a) + int'(fc_a), 0);
        chk("rst_ctl_b", idx, int'(ctl_b), int'(IDLE));
        chk("rst_state_b", idx, int'(st_b), 0);
        chk("rst_cnt_b", idx, int'(sc_b) + int'(fc_b), 0);
    endtask
    task automatic do_reset(input int idx);
        @(posedge clk);
        #2;
        {ex_mem_read, ex_branch_taken, mem_busy} = '0;
        rst_n = 1'b0;
        #1;
        chk_reset(idx);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask
    initial begin
        // Instance a: 1-cycle stall/flush, 4-bit counters.
        add(1, 0, R,   5, 7, 1, 5, 1, 0, FLO,  0, 0, 0);
        add(0, 0, R,   5, 7, 0, 5, 0, 0, IDLE, 0, 0, 1);
        add(0, 0, R,   5, 7, 1, 5, 0, 0, STL,  0, 0, 1);
        add(0, 0, R,   5, 7, 0, 5, 0, 0, IDLE, 0, 1, 1);
        add(0, 0, R,   0, 7, 1, 0, 0, 0, IDLE, 0, 1, 1);
        add(0, 0, I,   1, 5, 1, 5, 0, 0, IDLE, 0, 1, 1);
        add(0, 0, LUI, 5, 5, 1, 5, 0, 0, IDLE, 0, 1, 1);
        add(0, 0, S,   2, 5, 1, 5, 0, 0, STL,  0, 1, 1);
        add(0, 0, S,   2, 5, 0, 5, 0, 0, IDLE, 0, 2, 1);
        add(0, 0, R,   5, 7, 1, 5, 0, 1, FRZ,  0, 2, 1);
        add(0, 0, R,   5, 7, 1, 5, 0, 0, FRZ,  3, 2, 1);
        add(0, 0, R,   5, 7, 1, 5, 0, 0, STL,  0, 2, 1);
        add(0, 0, R,   5, 7, 0, 5, 0, 0, IDLE, 0, 3, 1);
        for (int k = 0; k < 20; k++) add(0, 0, R, 1, 2, 0, 0, 1, 0, FLO, 0, 3, (k + 1 > 15) ? 15 : k + 1);
        add(0, 0, R,   1, 2, 0, 0, 0, 0, IDLE, 0, 3, 15);
        // Instance b: 3-cycle stall/flush.
        add(1, 1, S,   2, 5, 1, 5, 0, 0, STL,  0, 0, 0);
        add(0, 1, S,   2, 5, 0, 5, 0, 0, STL,  1, 1, 0);
        add(0, 1, S,   2, 5, 0, 5, 0, 0, STL,  1, 2, 0);
        add(0, 1, S,   2, 5, 0, 5, 0, 0, IDLE, 0, 3, 0);
        add(0, 1, S,   2, 5, 1, 5, 0, 0, STL,  0, 3, 0);
        add(0, 1, S,   2, 5, 0, 5, 0, 1, FRZ,  1, 4, 0);
        add(0, 1, S,   2, 5, 0, 5, 0, 1, FRZ,  3, 4, 0);
        add(0, 1, S,   2, 5, 0, 5, 0, 1, FRZ,  3, 4, 0);
        add(0, 1, S,   2, 5, 0, 5, 0, 1, FRZ,  3, 4, 0);
        add(0, 1, S,   2, 5, 0, 5, 0, 0, FRZ,  3, 4, 0);
        add(0, 1, S,   2, 5, 0, 5, 0, 0, STL,  1, 4, 0);
        add(0, 1, S,   2, 5, 0, 5, 0, 0, STL,  1, 5, 0);
        add(0, 1, S,   2, 5, 0, 5, 0, 0, IDLE, 0, 6, 0);
        add(0, 1, S,   2, 5, 0, 5, 1, 0, FLO,  0, 6, 0);
        add(0, 1, S,   2, 5, 0, 5, 0, 0, FLO,  2, 6, 1);
        add(0, 1, S,   2, 5, 0, 5, 0, 0, FLO,  2, 6, 2);
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst) do_reset(i);
            @(posedge clk);
            #1;
            id_opcode = v.op; id_rs1 = v.rs1; id_rs2 = v.rs2; ex_mem_read = v.mr;
            ex_rd = v.rd; ex_branch_taken = v.br; mem_busy = v.mb;
            exp_q.push_back(v);
            #5;
            e = exp_q.pop_front();
            chk("ctl", i, e.sel ? int'(ctl_b) : int'(ctl_a), int'(e.ctl));
            chk("state", i, e.sel ? int'(st_b) : int'(st_a), int'(e.st));
            chk("stall_count", i, e.sel ? int'(sc_b) : int'(sc_a), e.sc);
            chk("flush_count", i, e.sel ? int'(fc_b) : int'(fc_a), e.fc);
        end
        // Still inside the last FLUSH cycle of instance b: reset must act without a clock edge.
        {ex_branch_taken, mem_busy} = '0;
        rst_n = 1'b0;
        #1;
        chk_reset(vecs.size());
        #5;
        rst_n = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
